// File: rtl/instr_seq.sv
// ---------------------------------------------------------------------------
// instr_seq -- instruction sequencer feeding the control unit (CU).
//
// Holds a small loadable program memory. After a start pulse it walks the
// program from address 0, fetching one word at a time and issuing its opcode
// and operand address to the CU. Each instruction is issued rep+1 times.
// A HALT opcode ends the run without being forwarded. Completing the last
// memory entry also ends the run, because the program counter does not wrap.
// Whenever nothing is being issued the opcode output shows NOP, so the
// combinational CU never re-executes a held instruction.
//
// Ports:
//   clk          system clock, all state changes on the rising edge
//   rst          synchronous active-high reset; overrides every other input
//   prog_we      program write strobe, honoured only while idle
//   prog_addr    program write address
//   prog_data    instruction word, packed {opcode, rep, addr}
//   start        run request, honoured only while idle
//   abort        return to idle from any state; beats stall and start
//   stall        datapath not ready, suppresses issue
//   opcode       opcode to the CU (NOP when not issuing)
//   operand      address field of the issued instruction (0 when not issuing)
//   issue_valid  opcode is a real issue this cycle
//   busy         sequencer is fetching or issuing
//   done         one-cycle pulse at the end of a run
//   pc           current program counter
// ---------------------------------------------------------------------------
module instr_seq #(
   parameter int OP_WIDTH   = 4,
   parameter int ADDR_WIDTH = 8,
   parameter int REP_WIDTH  = 4,
   parameter int DEPTH      = 16,
   parameter int PC_WIDTH   = 4
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   prog_we,
   input  logic [PC_WIDTH-1:0]                    prog_addr,
   input  logic [OP_WIDTH+REP_WIDTH+ADDR_WIDTH-1:0] prog_data,
   input  logic                                   start,
   input  logic                                   abort,
   input  logic                                   stall,
   output logic [OP_WIDTH-1:0]                    opcode,
   output logic [ADDR_WIDTH-1:0]                  operand,
   output logic                                   issue_valid,
   output logic                                   busy,
   output logic                                   done,
   output logic [PC_WIDTH-1:0]                    pc
);

   localparam int WORD_WIDTH = OP_WIDTH + REP_WIDTH + ADDR_WIDTH;

   // Opcode encodings shared with the CU: all ones is NOP, all ones with a
   // cleared LSB is HALT.
   localparam logic [OP_WIDTH-1:0]   OP_NOP   = {OP_WIDTH{1'b1}};
   localparam logic [OP_WIDTH-1:0]   OP_HALT  = {{(OP_WIDTH-1){1'b1}}, 1'b0};
   localparam logic [PC_WIDTH-1:0]   PC_ZERO  = {PC_WIDTH{1'b0}};
   localparam logic [PC_WIDTH-1:0]   PC_ONE   = {{(PC_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [PC_WIDTH-1:0]   PC_LAST  = PC_WIDTH'(DEPTH - 1);
   localparam logic [REP_WIDTH-1:0]  REP_ZERO = {REP_WIDTH{1'b0}};
   localparam logic [REP_WIDTH-1:0]  REP_ONE  = {{(REP_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
   localparam logic [WORD_WIDTH-1:0] WORD_ZERO = {WORD_WIDTH{1'b0}};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_ISSUE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Registered state
   state_t                state_r;
   logic [PC_WIDTH-1:0]   pc_r;
   logic [WORD_WIDTH-1:0] ir_r;
   logic [REP_WIDTH-1:0]  rep_cnt_r;
   logic [WORD_WIDTH-1:0] mem_r [DEPTH];

   // Next-state / control signals
   state_t                state_nxt_s;
   logic [PC_WIDTH-1:0]   pc_nxt_s;
   logic [REP_WIDTH-1:0]  rep_nxt_s;
   logic                  ir_load_s;
   logic                  mem_we_s;

   // Decoded fields of the instruction register
   logic [OP_WIDTH-1:0]   ir_op_s;
   logic [REP_WIDTH-1:0]  ir_rep_s;
   logic [ADDR_WIDTH-1:0] ir_addr_s;
   logic                  ir_halt_s;
   logic                  issue_s;

   assign ir_op_s   = ir_r[WORD_WIDTH-1 -: OP_WIDTH];
   assign ir_rep_s  = ir_r[ADDR_WIDTH +: REP_WIDTH];
   assign ir_addr_s = ir_r[ADDR_WIDTH-1:0];
   assign ir_halt_s = (ir_op_s == OP_HALT);

   // A real issue happens only in ISSUE with a non-HALT word and no stall.
   // abort does not mask it: the abort takes effect from the next cycle.
   assign issue_s = (state_r == ST_ISSUE) && !ir_halt_s && !stall;

   // Next-state and datapath control for the sequencer FSM.
   always_comb begin
      state_nxt_s = state_r;
      pc_nxt_s    = pc_r;
      rep_nxt_s   = rep_cnt_r;
      ir_load_s   = 1'b0;
      mem_we_s    = 1'b0;

      if (abort) begin
         state_nxt_s = ST_IDLE;
         pc_nxt_s    = PC_ZERO;
      end else begin
         case (state_r)
            ST_IDLE: begin
               // Write and start on the same edge: the write lands and the
               // run begins; the first fetch happens a cycle later, so it
               // already sees the new word.
               mem_we_s = prog_we && !rst;
               if (start) begin
                  pc_nxt_s    = PC_ZERO;
                  state_nxt_s = ST_FETCH;
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end
            ST_FETCH: begin
               ir_load_s   = 1'b1;
               rep_nxt_s   = REP_ZERO;
               state_nxt_s = ST_ISSUE;
            end
            ST_ISSUE: begin
               if (ir_halt_s) begin
                  state_nxt_s = ST_DONE;
               end else if (stall) begin
                  state_nxt_s = ST_ISSUE;
               end else if (rep_cnt_r < ir_rep_s) begin
                  rep_nxt_s   = rep_cnt_r + REP_ONE;
                  state_nxt_s = ST_ISSUE;
               end else if (pc_r == PC_LAST) begin
                  // No wrap: the last entry ends the run with pc held.
                  state_nxt_s = ST_DONE;
               end else begin
                  pc_nxt_s    = pc_r + PC_ONE;
                  state_nxt_s = ST_FETCH;
               end
            end
            ST_DONE: begin
               state_nxt_s = ST_IDLE;
            end
            default: begin
               state_nxt_s = ST_IDLE;
               pc_nxt_s    = PC_ZERO;
            end
         endcase
      end
   end

   // FSM state, program counter, repeat counter and instruction register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= ST_IDLE;
         pc_r      <= PC_ZERO;
         ir_r      <= WORD_ZERO;
         rep_cnt_r <= REP_ZERO;
      end else begin
         state_r   <= state_nxt_s;
         pc_r      <= pc_nxt_s;
         rep_cnt_r <= rep_nxt_s;
         if (ir_load_s) begin
            ir_r <= mem_r[pc_r];
         end else begin
            ir_r <= ir_r;
         end
      end
   end

   // Program memory; its contents survive reset by design.
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         mem_r[prog_addr] <= prog_data;
      end
   end

   // CU-facing outputs, decoded from registered state (and stall) so the CU
   // sees the issue in the same cycle.
   always_comb begin
      opcode      = OP_NOP;
      operand     = ADDR_ZERO;
      issue_valid = 1'b0;
      if (issue_s) begin
         opcode      = ir_op_s;
         operand     = ir_addr_s;
         issue_valid = 1'b1;
      end else begin
         opcode      = OP_NOP;
         operand     = ADDR_ZERO;
         issue_valid = 1'b0;
      end
   end

   assign busy = (state_r == ST_FETCH) || (state_r == ST_ISSUE);
   assign done = (state_r == ST_DONE);
   assign pc   = pc_r;

endmodule
